// File: rtl/traveler_op_pkg.sv
// -----------------------------------------------------------------------------
// traveler_op_pkg
// Shared constants for the traveler operation byte channel:
//   - channel tag owned by the operation decoder
//   - op field placement inside the byte and bit positions within the field
//   - idle (IGNORE) byte value
//   - executor op_code encodings
//   - helpers to validate and encode a one-hot op field
// -----------------------------------------------------------------------------
package traveler_op_pkg;

    // Channel tag carried in data_in[1:0] for operation bytes.
    localparam logic [1:0] CH_OP = 2'b10;

    // Op field location inside the byte.
    localparam int OP_LSB = 2;
    localparam int OP_MSB = 6;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;

    // Bit positions inside the op field.
    localparam int OP_BIT_GET      = 0;
    localparam int OP_BIT_PUT      = 1;
    localparam int OP_BIT_INTERACT = 2;
    localparam int OP_BIT_MOVE     = 3;
    localparam int OP_BIT_THROW    = 4;

    // Idle value on the channel: correct tag, empty op field.
    localparam logic [7:0] OP_IGNORE_BYTE = 8'h02;

    // Codes presented to the executor.
    localparam logic [2:0] OPC_GET      = 3'd0;
    localparam logic [2:0] OPC_PUT      = 3'd1;
    localparam logic [2:0] OPC_INTERACT = 3'd2;
    localparam logic [2:0] OPC_MOVE     = 3'd3;
    localparam logic [2:0] OPC_THROW    = 3'd4;

    // True when exactly one op bit is set.
    function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - 1'b1)) == '0);
    endfunction

    // Encode a one-hot op field. Only meaningful when op_is_onehot(op).
    function automatic logic [2:0] op_onehot_to_code(input logic [OP_W-1:0] op);
        logic [2:0] code;
        code = OPC_GET;
        if (op[OP_BIT_PUT])           code = OPC_PUT;
        else if (op[OP_BIT_INTERACT]) code = OPC_INTERACT;
        else if (op[OP_BIT_MOVE])     code = OPC_MOVE;
        else if (op[OP_BIT_THROW])    code = OPC_THROW;
        return code;
    endfunction

endpackage

// File: rtl/traveler_op_fifo.sv
// -----------------------------------------------------------------------------
// traveler_op_fifo
// Synchronous circular FIFO holding 3-bit op codes.
//   clk_i    system clock
//   rst_i    synchronous active-high reset, empties the FIFO
//   push_i   write din_i; accepted when not full, or when full and a pop
//            happens in the same cycle
//   pop_i    remove the head; ignored when empty
//   din_i    code to write
//   dout_o   head entry, 0 when empty (read straight from the array)
//   count_o  number of entries held
//   full_o   count_o == DEPTH
//   empty_o  count_o == 0
// -----------------------------------------------------------------------------
module traveler_op_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [2:0]               din_i,
    output logic [2:0]               dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? 3'd0 : mem_q[rd_ptr_q];

    // A pop on an empty FIFO is dropped; a pop on a full FIFO frees the slot
    // the same-cycle push lands in.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // DEPTH is a power of two, so pointer wrap is natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: dout_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/traveler_op_decoder.sv
// -----------------------------------------------------------------------------
// traveler_op_decoder
// Receives the traveler operation byte stream, detects newly issued commands,
// validates/encodes them and buffers them for the game-side executor.
//   clk         system clock
//   rst         synchronous active-high reset
//   data_in     operation byte: [1:0] channel tag, [6:2] one-hot op, [7] unused
//   op_valid    FIFO head holds a command
//   op_code     head command code (0 when empty)
//   op_ready    executor accepts the head this cycle
//   fifo_count  entries held
//   err_pulse   one-cycle pulse per malformed (non-one-hot) command
//   err_cnt     saturating malformed-command count
//   drop_cnt    saturating count of commands lost to a full FIFO
//
// Handshake: a command transfers on a rising edge where op_valid=1 and
// op_ready=1; op_valid/op_code do not depend on op_ready, op_ready may be
// high while op_valid=0 (no effect), and the next head is visible right
// after the transfer edge.
// -----------------------------------------------------------------------------
module traveler_op_decoder
    import traveler_op_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_in,
    output logic                   op_valid,
    output logic [2:0]             op_code,
    input  logic                   op_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_pulse,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    logic [7:0]      stage_q;
    logic [OP_W-1:0] prev_op_q,   prev_op_d;
    logic            err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [OP_W-1:0] stage_op;
    logic            chan_hit;
    logic            new_cmd;
    logic            cmd_onehot;
    logic            push_cmd;
    logic [2:0]      push_code;
    logic            fifo_full;
    logic            fifo_empty;
    logic            unused_bits;

    // Bit 7 of the byte carries no meaning on this channel.
    assign unused_bits = stage_q[7] ^ fifo_empty;

    assign stage_op   = stage_q[OP_MSB:OP_LSB];
    assign chan_hit   = (stage_q[1:0] == CH_OP);
    // Edge detect on the op field: a held byte issues one command, a direct
    // change to a different op issues another.
    assign new_cmd    = chan_hit && (stage_op != '0) && (stage_op != prev_op_q);
    assign cmd_onehot = op_is_onehot(stage_op);
    assign push_cmd   = new_cmd && cmd_onehot;
    assign push_code  = op_onehot_to_code(stage_op);

    always_comb begin
        // Foreign-channel bytes break the hold, so prev_op returns to idle.
        prev_op_d   = chan_hit ? stage_op : '0;
        err_pulse_d = new_cmd && !cmd_onehot;
        err_cnt_d   = err_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (err_pulse_d && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 1'b1;
        // Full with a same-cycle pop is not a drop: the pop frees the slot.
        if (push_cmd && fifo_full && !op_ready && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= OP_IGNORE_BYTE;
            prev_op_q   <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            stage_q     <= data_in;
            prev_op_q   <= prev_op_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    traveler_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_cmd),
        .pop_i   (op_ready),
        .din_i   (push_code),
        .dout_o  (op_code),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign op_valid  = ~fifo_empty;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_traveler_op_decoder.sv
// -----------------------------------------------------------------------------
// tb_traveler_op_decoder
// Directed bench for traveler_op_decoder with DEPTH=4, CNT_W=8.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_traveler_op_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       op_valid;
    logic [2:0] op_code;
    logic       op_ready;
    logic [2:0] fifo_count;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    traveler_op_decoder #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_ready   (op_ready),
        .fifo_count (fifo_count),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .drop_cnt   (drop_cnt)
    );

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One command byte followed by an IGNORE byte.
    task automatic send_cmd(input logic [7:0] b);
        data_in = b;
        tick(1);
        data_in = 8'h02;
        tick(1);
    endtask

    task automatic pop_one();
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, op_valid},   32'd0);
        chk({tag, "_code"},  {29'd0, op_code},    32'd0);
        chk({tag, "_count"}, {29'd0, fifo_count}, 32'd0);
        chk({tag, "_errp"},  {31'd0, err_pulse},  32'd0);
        chk({tag, "_errc"},  {24'd0, err_cnt},    32'd0);
        chk({tag, "_drop"},  {24'd0, drop_cnt},   32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        data_in  = 8'h02;
        op_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        chk_all_zero("reset");

        // Single GET: visible two edges after the byte is driven.
        data_in = 8'h06;
        tick(1);
        chk("get_lat1_valid", {31'd0, op_valid}, 32'd0);
        data_in = 8'h02;
        tick(1);
        chk("get_valid", {31'd0, op_valid},   32'd1);
        chk("get_code",  {29'd0, op_code},    32'd0);
        chk("get_count", {29'd0, fifo_count}, 32'd1);
        pop_one();
        chk("get_pop_valid", {31'd0, op_valid},   32'd0);
        chk("get_pop_count", {29'd0, fifo_count}, 32'd0);

        // Held PUT gives one entry; direct change to INTERACT gives another.
        data_in = 8'h0A;
        tick(10);
        chk("hold_count", {29'd0, fifo_count}, 32'd1);
        chk("hold_code",  {29'd0, op_code},    32'd1);
        data_in = 8'h12;
        tick(2);
        chk("chg_count", {29'd0, fifo_count}, 32'd2);
        chk("chg_head",  {29'd0, op_code},    32'd1);
        data_in  = 8'h02;
        pop_one();
        chk("chg_pop1_count", {29'd0, fifo_count}, 32'd1);
        chk("chg_pop1_code",  {29'd0, op_code},    32'd2);
        pop_one();
        chk("chg_pop2_count", {29'd0, fifo_count}, 32'd0);

        // Malformed GET|PUT: one error pulse, no entry.
        data_in = 8'h0E;
        tick(1);
        chk("mal_pre_errp", {31'd0, err_pulse}, 32'd0);
        data_in = 8'h02;
        tick(1);
        chk("mal_errp",  {31'd0, err_pulse},  32'd1);
        chk("mal_errc",  {24'd0, err_cnt},    32'd1);
        chk("mal_count", {29'd0, fifo_count}, 32'd0);
        tick(1);
        chk("mal_post_errp", {31'd0, err_pulse}, 32'd0);

        // Foreign channel: nothing happens.
        data_in = 8'h05;
        tick(3);
        chk("foreign_count", {29'd0, fifo_count}, 32'd0);
        chk("foreign_errc",  {24'd0, err_cnt},    32'd1);
        chk("foreign_errp",  {31'd0, err_pulse},  32'd0);
        data_in = 8'h02;
        tick(1);

        // Overflow: five commands into four slots.
        send_cmd(8'h22);
        send_cmd(8'h42);
        send_cmd(8'h06);
        send_cmd(8'h0A);
        send_cmd(8'h12);
        chk("ovf_count", {29'd0, fifo_count}, 32'd4);
        chk("ovf_drop",  {24'd0, drop_cnt},   32'd1);
        chk("ovf_pop0", {29'd0, op_code}, 32'd3); pop_one();
        chk("ovf_pop1", {29'd0, op_code}, 32'd4); pop_one();
        chk("ovf_pop2", {29'd0, op_code}, 32'd0); pop_one();
        chk("ovf_pop3", {29'd0, op_code}, 32'd1); pop_one();
        chk("ovf_empty", {29'd0, fifo_count}, 32'd0);

        // Full boundary: push THROW while popping the head.
        send_cmd(8'h06);
        send_cmd(8'h0A);
        send_cmd(8'h12);
        send_cmd(8'h22);
        chk("fb_fill", {29'd0, fifo_count}, 32'd4);
        data_in = 8'h42;
        tick(1);
        data_in  = 8'h02;
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        chk("fb_count", {29'd0, fifo_count}, 32'd4);
        chk("fb_drop",  {24'd0, drop_cnt},   32'd1);
        chk("fb_pop0", {29'd0, op_code}, 32'd1); pop_one();
        chk("fb_pop1", {29'd0, op_code}, 32'd2); pop_one();
        chk("fb_pop2", {29'd0, op_code}, 32'd3); pop_one();
        chk("fb_pop3", {29'd0, op_code}, 32'd4); pop_one();
        chk("fb_empty", {31'd0, op_valid}, 32'd0);

        // Saturation: 1 + 300 malformed commands.
        for (int i = 0; i < 300; i++) send_cmd(8'h0E);
        chk("sat_errc", {24'd0, err_cnt}, 32'd255);
        send_cmd(8'h0E);
        send_cmd(8'h0E);
        chk("sat_hold", {24'd0, err_cnt},    32'd255);
        chk("sat_count", {29'd0, fifo_count}, 32'd0);

        // Reset mid-stream with THROW on the input.
        send_cmd(8'h06);
        send_cmd(8'h0A);
        send_cmd(8'h22);
        chk("rms_fill", {29'd0, fifo_count}, 32'd3);
        data_in = 8'h42;
        rst     = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all_zero("rms_now");
        data_in = 8'h02;
        tick(3);
        chk_all_zero("rms_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traveler_op_decoder.md
# traveler_op_decoder

Receiving end of the traveler operation byte channel. Samples the 8-bit operation byte stream produced by the button front end, detects each newly issued command, validates and one-hot-decodes it, and buffers it in a small FIFO. A valid/ready handshake then presents the commands in order to the game-side executor. Malformed and dropped commands are counted for debug display.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CNT_W`, 8: width of the error and drop counters.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `data_in` in 8: operation byte.
  - [1:0] channel tag.
  - [6:2] op field: bit2 GET, bit3 PUT, bit4 INTERACT, bit5 MOVE, bit6 THROW.
  - [7] don't-care.
- `op_valid` out 1: FIFO head holds a command.
- `op_code` out 3: head command, 0 GET, 1 PUT, 2 INTERACT, 3 MOVE, 4 THROW; 0 when empty.
- `op_ready` in 1: executor accepts the head this cycle.
- `fifo_count` out $clog2(DEPTH)+1: number of entries held.
- `err_pulse` out 1: one-cycle pulse on a malformed command.
- `err_cnt` out CNT_W: saturating count of malformed commands.
- `drop_cnt` out CNT_W: saturating count of commands lost because the FIFO was full.

## Operation
- **Stage register.** `data_in` is registered into `stage` every cycle. `prev_op` holds the op field of the previous `stage` value.
- **Channel filter.**
  - `stage[1:0]` ≠ 2'b10: the byte belongs to another channel. It is ignored entirely and `prev_op` is set to 0.
  - `stage[1:0]` = 2'b10 with op field 0 is IGNORE, the idle value.
- **New-command detect.** A byte is a new command when the channel is 2'b10, its op field ≠ 0, and its op field ≠ `prev_op`.
  - A held byte, i.e. the same op on consecutive cycles, produces exactly one command.
  - An op change without an intervening IGNORE produces a new command.
- **Validation.**
  - New command with an op field that is not one-hot: `err_pulse`=1 for one cycle, `err_cnt` increments (saturating at all-ones), nothing is written.
  - New command with a one-hot op field: encoded to `op_code` and pushed into the FIFO.
- **Drop on full.** A push while the FIFO is full and `op_ready`=0 (no pop) discards the command; `drop_cnt` increments (saturating).
- **Simultaneous push and pop.**
  - When full: the pop frees a slot, the push is accepted, and the count is unchanged.
  - When empty: `op_ready` is ignored and the push is accepted.
- **FIFO.** Circular, with read/write pointers that wrap modulo DEPTH. `op_valid` = (count ≠ 0). `op_code` is the head entry, driven from the registered array with no extra latency.
- **Reset.** Applies at any point, including mid-stream.
  - `stage`=8'h02 (IGNORE), `prev_op`=0.
  - FIFO emptied: `op_valid`=0, `op_code`=0, `fifo_count`=0.
  - `err_pulse`=0, `err_cnt`=0, `drop_cnt`=0.
  - Commands already buffered are lost.
  - A byte present during the reset cycle is not captured.

## Timing
- A byte on `data_in` at rising edge k is in `stage` after edge k.
- Decode is combinational on `stage`. The FIFO write, `err_pulse` and the counter updates occur at edge k+1.
- `op_valid` rises after edge k+1 when the FIFO was empty: a 2-cycle latency from input to output.
- A pop occurs at the edge where `op_valid`=1 and `op_ready`=1; the next head is visible after that edge.
- Throughput is one push and one pop per cycle.
- `err_pulse` is high exactly one cycle per malformed command.
- Counters stop at 2^CNT_W−1 and do not wrap.

## Structure
- **Package `traveler_op_pkg`:**
  - `CH_OP` = 2'b10.
  - Op field bit positions.
  - `OP_IGNORE_BYTE` = 8'h02.
  - `op_code` encodings `OPC_GET`..`OPC_THROW`.
  - The one-hot-to-code function.
- **Sub-module `traveler_op_fifo`:** synchronous FIFO with parameter DEPTH and width 3.
  - Inputs: push, pop, din.
  - Outputs: dout, count, full, empty.
  - The top level keeps the stage register, detect/validate logic, and counters.

## Test plan
- **Single command, then pop.** Drive 8'h02, then 8'h06 (GET) for 1 cycle, then 8'h02, with `op_ready`=0 → `op_valid` rises 2 cycles after 8'h06 with `op_code`=0. Raise `op_ready` for one cycle → `op_valid`=0 and `fifo_count`=0.
- **Held and changed bytes.** Hold 8'h0A (PUT) for 10 cycles → exactly one entry with `op_code`=1. Then 8'h0A → 8'h12 (INTERACT) directly → a second entry with `op_code`=2.
- **Malformed and foreign-channel bytes.** 8'h0E (GET|PUT) → `err_pulse` for 1 cycle, `err_cnt`=1, no entry. 8'h05 (channel 01) → no entry, no error.
- **Overflow and full-boundary push/pop.** With DEPTH=4 and `op_ready`=0, send MOVE, THROW, GET, PUT, INTERACT (each separated by IGNORE) → `fifo_count`=4, `drop_cnt`=1, pops return codes 3,4,0,1. Separately, fill to 4, then push and pop in the same cycle → count stays 4 and the new entry is last.
- **Saturation.** Send 300 malformed commands → `err_cnt`=255 and stays there.
- **Reset mid-stream.** With 3 entries buffered, assert `rst` for 1 cycle while 8'h42 (THROW) is on `data_in` → all outputs 0, and no THROW appears afterward.
